nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Control FSM that sequences the shared forward-pass datapath of the drowsiness ANN: hidden-layer multiply-accumulate, hidden activation, output-layer multiply-accumulate, output activation, and the optional output-weight update pass.
- Replaces ad-hoc per-state counters with one registered scheduler.
- Drives the weight-memory read enable, the input/neuron index, the accumulator clear and enable strobes, the activation-register loads and the update strobes.
- The datapath owns the arithmetic; this block owns only timing.

Parameters:
- N_IN, 30, number of network inputs (hidden-layer MAC length).
- N_HID, 5, number of hidden neurons (output-layer MAC length and update length).
- IDX_W, 5, width of idx; must satisfy 2^IDX_W >= max(N_IN, N_HID).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  request one forward pass; sampled only in IDLE.
- training  input  1  sampled with Start; when 1, the update pass follows the forward pass.
- hold  input  1  stall; freezes the sequencer (see Behaviour).
- busy  output  1  high in every state except IDLE.
- layer  output  1  0 = hidden-layer phase, 1 = output-layer or update phase; steers datapath muxes.
- idx  output  IDX_W  current input index (hidden), hidden-neuron index (output) or weight column (update).
- rd_en  output  1  weight/input read strobe for idx; memory returns data 1 cycle later.
- mac_clr  output  1  clear all accumulators of the current layer.
- mac_en  output  1  accumulate memory data; equals rd_en delayed one cycle.
- af_load_hid  output  1  latch hidden activation outputs.
- af_load_out  output  1  latch output activation outputs.
- upd_en  output  1  apply the delta to output weights at column idx.
- done  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- All outputs are registered (Moore).
- Reset values: state IDLE; idx 0; layer 0; busy, rd_en, mac_clr, mac_en, af_load_hid, af_load_out, upd_en and done all 0. The training latch is 0.
- Reset asserted mid-pass aborts immediately to IDLE. No done pulse is generated.
- States and transitions:
  - IDLE: on Start=1, latch training and go to HCLR. Otherwise stay.
  - HCLR: mac_clr=1, layer=0, 1 cycle, then go to HMAC.
  - HMAC: rd_en=1; idx steps 0..N_IN-1, one per cycle. After idx=N_IN-1, go to HDRAIN.
  - HDRAIN: 1 cycle; mac_en is still high from the last read.
  - HACT: af_load_hid=1, 1 cycle.
  - OCLR: mac_clr=1, layer=1.
  - OMAC: rd_en=1; idx steps 0..N_HID-1.
  - ODRAIN: 1 cycle.
  - OACT: af_load_out=1. Then go to UPD if training was latched, otherwise to DONE.
  - UPD: upd_en=1, layer=1; idx steps 0..N_HID-1, then go to DONE.
  - DONE: done=1 for 1 cycle, then go to IDLE.
- idx is 0 in all states other than HMAC, OMAC and UPD.
- mac_en(t) = rd_en(t-1) whenever hold is low. idx never wraps; the terminal compare is exact.
- Latency: with Start accepted at edge 0, done is high in cycle N_IN+N_HID+7 (42 for the defaults). With training, done is high in cycle N_IN+2*N_HID+7 (47).
- busy rises in the cycle after Start is accepted and falls in the cycle after done.
- Start outside IDLE, including the DONE cycle, is ignored and not queued.
- A Start sampled in the IDLE cycle right after DONE is accepted, so back-to-back passes are allowed.
- A change to training after acceptance has no effect on the current pass.
- hold=1:
  - State, idx, the training latch and the mac_en pipeline register are frozen.
  - rd_en, mac_en, mac_clr, af_load_hid, af_load_out, upd_en and done are forced to 0 while hold is high.
  - busy and layer keep their values.
  - On hold release, the frozen strobe pattern resumes exactly where it stopped. A held DONE state re-emits done on release.
- hold in IDLE also blocks Start acceptance.
- Simultaneous Start and hold in IDLE: hold wins and Start is not accepted.

Test Plan:
- Reset, then Start=1 for one cycle with training=0. Required: 30 consecutive rd_en cycles with idx 0..29, each followed one cycle later by mac_en; af_load_hid in cycle 33; 5 rd_en cycles with idx 0..4 and layer=1; af_load_out in cycle 41; done in cycle 42; busy low in cycle 43.
- Start with training=1. Required: 5 upd_en cycles with idx 0..4 in cycles 42..46 and done in cycle 47. Toggling training mid-pass changes nothing.
- Assert hold for 3 cycles while idx=10 in HMAC. Required: rd_en and mac_en are 0 and idx stays 10 for those 3 cycles; the sequence then resumes at idx 10 with mac_en for idx 9 delivered first; done arrives 3 cycles late (cycle 45).
- Pulse Start in cycle 20 and again during the DONE cycle. Required: both are ignored. Start held high through DONE is accepted in the following IDLE cycle, with the next done 43 cycles later.
- Drop Rst in cycle 36 (OMAC). Required: all outputs are 0 and state is IDLE asynchronously, with no done. A Start after release produces a full pass with done in cycle 42.
- Start and hold both high in IDLE. Required: busy stays 0. On hold release with Start still high, acceptance occurs on that edge.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Timing scheduler for the shared ANN forward-pass datapath: hidden MAC, hidden
// activation, output MAC, output activation and optional output-weight update.
module nn_layer_sequencer #(
    parameter int N_IN  = 30,
    parameter int N_HID = 5,
    parameter int IDX_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_training,
    input  logic             i_hold,
    output logic             o_busy,
    output logic             o_layer,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_rd_en,
    output logic             o_mac_clr,
    output logic             o_mac_en,
    output logic             o_af_load_hid,
    output logic             o_af_load_out,
    output logic             o_upd_en,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] LAST_HID = IDX_W'(N_HID - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HCLR,
        S_HMAC,
        S_HDRAIN,
        S_HACT,
        S_OCLR,
        S_OMAC,
        S_ODRAIN,
        S_OACT,
        S_UPD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_train;
    logic             r_busy;
    logic             r_layer;
    logic             r_rd_en;
    logic             r_mac_clr;
    logic             r_mac_en;
    logic             r_af_hid;
    logic             r_af_out;
    logic             r_upd_en;
    logic             r_done;

    // Each transition loads the strobes of the state being entered, so every
    // output is a register; hold freezes everything, including the mac_en pipe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_train   <= 1'b0;
            r_busy    <= 1'b0;
            r_layer   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_mac_clr <= 1'b0;
            r_mac_en  <= 1'b0;
            r_af_hid  <= 1'b0;
            r_af_out  <= 1'b0;
            r_upd_en  <= 1'b0;
            r_done    <= 1'b0;
        end else if (!i_hold) begin
            r_mac_en  <= r_rd_en;
            r_rd_en   <= 1'b0;
            r_mac_clr <= 1'b0;
            r_af_hid  <= 1'b0;
            r_af_out  <= 1'b0;
            r_upd_en  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_train   <= i_training;
                        r_state   <= S_HCLR;
                        r_busy    <= 1'b1;
                        r_layer   <= 1'b0;
                        r_idx     <= '0;
                        r_mac_clr <= 1'b1;
                    end
                end
                S_HCLR: begin
                    r_state <= S_HMAC;
                    r_idx   <= '0;
                    r_rd_en <= 1'b1;
                end
                S_HMAC: begin
                    if (r_idx == LAST_IN) begin
                        r_state <= S_HDRAIN;
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_rd_en <= 1'b1;
                    end
                end
                S_HDRAIN: begin
                    r_state  <= S_HACT;
                    r_af_hid <= 1'b1;
                end
                S_HACT: begin
                    r_state   <= S_OCLR;
                    r_layer   <= 1'b1;
                    r_mac_clr <= 1'b1;
                end
                S_OCLR: begin
                    r_state <= S_OMAC;
                    r_idx   <= '0;
                    r_rd_en <= 1'b1;
                end
                S_OMAC: begin
                    if (r_idx == LAST_HID) begin
                        r_state <= S_ODRAIN;
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_rd_en <= 1'b1;
                    end
                end
                S_ODRAIN: begin
                    r_state  <= S_OACT;
                    r_af_out <= 1'b1;
                end
                S_OACT: begin
                    r_idx <= '0;
                    if (r_train) begin
                        r_state  <= S_UPD;
                        r_upd_en <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_UPD: begin
                    if (r_idx == LAST_HID) begin
                        r_state <= S_DONE;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_upd_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_layer <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_layer <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Strobes are masked while stalled so the datapath sees no side effects;
    // the frozen registers replay them once hold drops.
    assign o_busy        = r_busy;
    assign o_layer       = r_layer;
    assign o_idx         = r_idx;
    assign o_rd_en       = r_rd_en   & ~i_hold;
    assign o_mac_clr     = r_mac_clr & ~i_hold;
    assign o_mac_en      = r_mac_en  & ~i_hold;
    assign o_af_load_hid = r_af_hid  & ~i_hold;
    assign o_af_load_out = r_af_out  & ~i_hold;
    assign o_upd_en      = r_upd_en  & ~i_hold;
    assign o_done        = r_done    & ~i_hold;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: each accepted Start pushes the
// cycle-by-cycle expected output trace, which is popped and compared every cycle.
module tb_nn_layer_sequencer;

    localparam int N_IN  = 30;
    localparam int N_HID = 5;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             training;
    logic             hold;
    logic             busy;
    logic             layer;
    logic [IDX_W-1:0] idx;
    logic             rd_en;
    logic             mac_clr;
    logic             mac_en;
    logic             af_load_hid;
    logic             af_load_out;
    logic             upd_en;
    logic             done;

    nn_layer_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .IDX_W(IDX_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_training    (training),
        .i_hold        (hold),
        .o_busy        (busy),
        .o_layer       (layer),
        .o_idx         (idx),
        .o_rd_en       (rd_en),
        .o_mac_clr     (mac_clr),
        .o_mac_en      (mac_en),
        .o_af_load_hid (af_load_hid),
        .o_af_load_out (af_load_out),
        .o_upd_en      (upd_en),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, layer, idx[4:0], rd_en, mac_clr, mac_en, af_hid, af_out, upd_en, done}
    logic [13:0] out_vec;
    assign out_vec = {busy, layer, idx, rd_en, mac_clr, mac_en,
                      af_load_hid, af_load_out, upd_en, done};

    typedef struct {
        logic [13:0] v;
        int          p;
        int          c;
    } exp_t;

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   pass_id = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] mk(input bit b, input bit l, input int i, input bit rd,
                                       input bit clr, input bit men, input bit ah,
                                       input bit ao, input bit up, input bit dn);
        logic [4:0] iv;
        iv = 5'(i);
        return {b, l, iv, rd, clr, men, ah, ao, up, dn};
    endfunction

    // Expected outputs in cycle c after a Start accepted at edge 0 (c=0 is the accept cycle).
    function automatic logic [13:0] exp_at(input int c, input bit tr);
        int done_c;
        done_c = tr ? (N_IN + 2*N_HID + 7) : (N_IN + N_HID + 7);
        if (c == 0)                                   return '0;
        if (c == 1)                                   return mk(1,0,0, 0,1,0,0,0,0,0);
        if (c >= 2 && c <= N_IN + 1)                  return mk(1,0,c-2, 1,0,(c>=3),0,0,0,0);
        if (c == N_IN + 2)                            return mk(1,0,0, 0,0,1,0,0,0,0);
        if (c == N_IN + 3)                            return mk(1,0,0, 0,0,0,1,0,0,0);
        if (c == N_IN + 4)                            return mk(1,1,0, 0,1,0,0,0,0,0);
        if (c >= N_IN + 5 && c <= N_IN + N_HID + 4)
            return mk(1,1,c-(N_IN+5), 1,0,(c>=N_IN+6),0,0,0,0);
        if (c == N_IN + N_HID + 5)                    return mk(1,1,0, 0,0,1,0,0,0,0);
        if (c == N_IN + N_HID + 6)                    return mk(1,1,0, 0,0,0,0,1,0,0);
        if (c == done_c)                              return mk(1,1,0, 0,0,0,0,0,0,1);
        if (tr && c >= N_IN + N_HID + 7 && c <= N_IN + 2*N_HID + 6)
            return mk(1,1,c-(N_IN+N_HID+7), 0,0,0,0,0,1,0);
        return '0;
    endfunction

    // A stall inserted at cycle hold_at repeats that cycle with strobes masked.
    task automatic push_pass(input bit tr, input int hold_at, input int hold_len);
        int   done_c;
        exp_t e;
        pass_id++;
        done_c = tr ? (N_IN + 2*N_HID + 7) : (N_IN + N_HID + 7);
        for (int c = 0; c <= done_c; c++) begin
            if (c == hold_at) begin
                for (int h = 0; h < hold_len; h++) begin
                    e.v = exp_at(c, tr) & 14'h3F80;
                    e.p = pass_id;
                    e.c = c;
                    q.push_back(e);
                end
            end
            e.v = exp_at(c, tr);
            e.p = pass_id;
            e.c = c;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [13:0] obs;
        if (rst_n) begin
            obs = out_vec;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (!e.v[13]) obs[12] = e.v[12];
                check_val($sformatf("p%0d_c%0d", e.p, e.c), {18'd0, obs}, {18'd0, e.v});
            end else begin
                obs[12] = 1'b0;
                check_val("idle", {18'd0, obs}, 32'd0);
            end
            if (done) $display("pass done at %0t", $time);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        training = 1'b0;
        hold     = 1'b0;
        step(3);
        check_val("reset_outs", {18'd0, out_vec}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Plain pass; Start pulses in cycle 20 and in DONE, training flip mid-pass.
        start = 1'b1; training = 1'b0; push_pass(0, -1, 0);
        step(1); start = 1'b0;
        step(19); start = 1'b1; training = 1'b1;
        step(1);  start = 1'b0;
        step(21); start = 1'b1;
        step(1);  start = 1'b0; training = 1'b0;
        step(3);

        // Training pass with training toggled after acceptance.
        start = 1'b1; training = 1'b1; push_pass(1, -1, 0);
        step(1);  start = 1'b0;
        step(4);  training = 1'b0;
        step(20); training = 1'b1;
        step(10); training = 1'b0;
        step(16);

        // 3-cycle stall while idx=10 in the hidden MAC.
        start = 1'b1; push_pass(0, 12, 3);
        step(1);  start = 1'b0;
        step(11); hold = 1'b1;
        step(3);  hold = 1'b0;
        step(33);

        // Start held through DONE is accepted in the following IDLE cycle.
        start = 1'b1; push_pass(0, -1, 0);
        step(1);  start = 1'b0;
        step(41); start = 1'b1;
        step(1);  push_pass(0, -1, 0);
        step(1);  start = 1'b0;
        step(44);

        // Asynchronous reset during OMAC, then a full pass.
        start = 1'b1; push_pass(0, -1, 0);
        step(1);  start = 1'b0;
        step(35);
        q.delete();
        #2 rst_n = 1'b0;
        #1 check_val("async_rst", {18'd0, out_vec}, 32'd0);
        step(2);
        check_val("rst_held", {18'd0, out_vec}, 32'd0);
        #3 rst_n = 1'b1;
        step(1);
        start = 1'b1; push_pass(0, -1, 0);
        step(1);  start = 1'b0;
        step(44);

        // Start and hold together in IDLE: hold wins until released.
        start = 1'b1; hold = 1'b1;
        step(1); check_val("hold_idle_busy1", {31'd0, busy}, 32'd0);
        step(1); check_val("hold_idle_busy2", {31'd0, busy}, 32'd0);
        step(1); check_val("hold_idle_busy3", {31'd0, busy}, 32'd0);
        hold = 1'b0; push_pass(0, -1, 0);
        step(1); start = 1'b0;
        check_val("hold_release_busy", {31'd0, busy}, 32'd1);
        step(44);

        check_val("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
